// File: rtl/ball_sched_pkg.sv
// rtl/ball_sched_pkg.sv - shared constants, state type and helpers for ball_move_sched
// Purpose: arrow keycodes, scheduler state enum, demo walk sequence and the
//          direction-key test used by the scheduler and its bench.
// Ports:   none (package).
package ball_sched_pkg;

  localparam logic [7:0] KEY_RIGHT = 8'd79;
  localparam logic [7:0] KEY_LEFT  = 8'd80;
  localparam logic [7:0] KEY_DOWN  = 8'd81;
  localparam logic [7:0] KEY_UP    = 8'd82;

  typedef enum logic {ST_RUN, ST_DEMO} ball_state_e;

  // Demo walk: right, down, left, up. Element 0 is issued first.
  localparam logic [3:0][7:0] DEMO_SEQ = {KEY_UP, KEY_LEFT, KEY_DOWN, KEY_RIGHT};

  // The four arrow codes are contiguous, so a range test covers them.
  function automatic logic is_dir_key(input logic [7:0] code);
    return (code >= KEY_RIGHT) && (code <= KEY_UP);
  endfunction

endpackage

// File: rtl/ball_cmd_fifo.sv
// rtl/ball_cmd_fifo.sv - command FIFO between the arbiter and the issue stage
// Purpose: synchronous FIFO, DEPTH entries (power of 2), head visible combinationally.
// Ports:   frame_clk, Reset (async, active-high)
//          push_i/push_data_i  enqueue (ignored when full)
//          pop_i/head_o        dequeue / current head (ignored when empty)
//          full_o, empty_o, count_o (0..DEPTH)
module ball_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of 2; count is kept
  // separately so full and empty are distinguishable.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge frame_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ball_move_sched.sv
// rtl/ball_move_sched.sv - two-source arrow-key scheduler feeding the ball motion block
// Purpose: edge-detects new arrow presses from two requesters, holds one pending
//          code per source, arbitrates round-robin into a command FIFO and issues
//          at most one one-frame Keycode pulse every GAP_FRAMES frames.
//          Optional demo walk when idle: enabled by defining BALL_SCHED_DEMO_EN.
// Ports:   frame_clk, Reset (async, active-high)
//          KeyA, KeyB   requester keycodes (0 = none)
//          Keycode      issued command, 0 except on issue frames
//          Demo         high while in demo mode
//          Fifo_count   FIFO occupancy
//          Grant        one-hot source of the last push (A=01, B=10)
module ball_move_sched
  import ball_sched_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_FRAMES  = 8,
  parameter int IDLE_FRAMES = 600,
  parameter int DEMO_PERIOD = 60
) (
  input  logic                        frame_clk,
  input  logic                        Reset,
  input  logic [7:0]                  KeyA,
  input  logic [7:0]                  KeyB,
  output logic [7:0]                  Keycode,
  output logic                        Demo,
  output logic [$clog2(FIFO_DEPTH):0] Fifo_count,
  output logic [1:0]                  Grant
);

  localparam int            GW         = $clog2(GAP_FRAMES) + 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_FRAMES - 1);

  logic [7:0]    prev_a_q, prev_b_q;
  logic [7:0]    pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic          pend_a_vld_q, pend_a_vld_d, pend_b_vld_q, pend_b_vld_d;
  logic          rr_q, rr_d;        // 0: A wins a tie, 1: B wins a tie
  logic [1:0]    grant_q, grant_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    keycode_q, keycode_d, fifo_key;
  logic          new_a, new_b, push_a, push_b, push, pop;
  logic [7:0]    push_data, head;
  logic          full, empty;

  assign new_a = (KeyA != prev_a_q) && is_dir_key(KeyA);
  assign new_b = (KeyB != prev_b_q) && is_dir_key(KeyB);

  // Arbitration looks only at pre-edge pending state, so a code loaded on
  // this edge cannot be pushed before the next one. Full is also pre-edge:
  // a simultaneous pop does not make room for this edge's push.
  assign push_a    = !full && pend_a_vld_q && (!pend_b_vld_q || !rr_q);
  assign push_b    = !full && pend_b_vld_q && (!pend_a_vld_q || rr_q);
  assign push      = push_a || push_b;
  assign push_data = push_a ? pend_a_q : pend_b_q;
  assign pop       = (gap_q == '0) && !empty;

  ball_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .count_o     (Fifo_count)
  );

  always_comb begin
    pend_a_d     = pend_a_q;
    pend_b_d     = pend_b_q;
    pend_a_vld_d = pend_a_vld_q;
    pend_b_vld_d = pend_b_vld_q;
    // A new sample wins over the clear of a slot pushed on the same edge.
    if (push_a) pend_a_vld_d = 1'b0;
    if (push_b) pend_b_vld_d = 1'b0;
    if (new_a) begin
      pend_a_d     = KeyA;
      pend_a_vld_d = 1'b1;
    end
    if (new_b) begin
      pend_b_d     = KeyB;
      pend_b_vld_d = 1'b1;
    end
    rr_d    = (pend_a_vld_q && pend_b_vld_q && push) ? ~rr_q : rr_q;
    grant_d = push_a ? 2'b01 : (push_b ? 2'b10 : grant_q);
    if (pop) begin
      gap_d    = GAP_RELOAD;
      fifo_key = head;
    end else begin
      gap_d    = (gap_q != '0) ? gap_q - 1'b1 : '0;
      fifo_key = '0;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      prev_a_q     <= '0;
      prev_b_q     <= '0;
      pend_a_q     <= '0;
      pend_b_q     <= '0;
      pend_a_vld_q <= 1'b0;
      pend_b_vld_q <= 1'b0;
      rr_q         <= 1'b0;
      grant_q      <= '0;
      gap_q        <= '0;
      keycode_q    <= '0;
    end else begin
      prev_a_q     <= KeyA;
      prev_b_q     <= KeyB;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      pend_a_vld_q <= pend_a_vld_d;
      pend_b_vld_q <= pend_b_vld_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      gap_q        <= gap_d;
      keycode_q    <= keycode_d;
    end
  end

  assign Keycode = keycode_q;
  assign Grant   = grant_q;

`ifdef BALL_SCHED_DEMO_EN
  localparam int IW = $clog2(IDLE_FRAMES) + 1;
  localparam int TW = $clog2(DEMO_PERIOD) + 1;

  ball_state_e   state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [1:0]    demo_idx_q, demo_idx_d;
  logic [TW-1:0] demo_tmr_q, demo_tmr_d;
  logic          idle_frame;

  assign idle_frame = !new_a && !new_b && !pend_a_vld_q && !pend_b_vld_q && empty;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_RUN;
      idle_q     <= '0;
      demo_idx_q <= '0;
      demo_tmr_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_q     <= idle_d;
      demo_idx_q <= demo_idx_d;
      demo_tmr_q <= demo_tmr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_d     = idle_q;
    demo_idx_d = demo_idx_q;
    demo_tmr_d = demo_tmr_q;
    keycode_d  = fifo_key;
    case (state_q)
      ST_RUN: begin
        if (!idle_frame) begin
          idle_d = '0;
        end else if (idle_q == IW'(IDLE_FRAMES - 1)) begin
          state_d    = ST_DEMO;
          idle_d     = '0;
          demo_idx_d = '0;
          demo_tmr_d = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_DEMO: begin
        // FIFO is always empty here; any new press ends the demo at once
        // and the press itself is handled by the normal pending path.
        keycode_d = '0;
        if (new_a || new_b) begin
          state_d = ST_RUN;
          idle_d  = '0;
        end else if (demo_tmr_q == '0) begin
          keycode_d  = DEMO_SEQ[demo_idx_q];
          demo_idx_d = demo_idx_q + 1'b1;
          demo_tmr_d = TW'(DEMO_PERIOD - 1);
        end else begin
          demo_tmr_d = demo_tmr_q - 1'b1;
        end
      end
    endcase
  end

  assign Demo = (state_q == ST_DEMO);
`else
  logic unused_demo_cfg;
  assign unused_demo_cfg = (IDLE_FRAMES > 0) ^ (DEMO_PERIOD > 0);
  assign keycode_d       = fifo_key;
  assign Demo            = 1'b0;
`endif

endmodule
